// File: rtl/ssp_pkg.sv
// ssp_pkg: constants shared by the SSP sequencer block.
// Contents: opcode values, alu_op select encodings, the FSM state encoding,
// the default memory-wait limit, and small opcode-classification helpers.
package ssp_pkg;

    localparam int WAIT_MAX_DEFAULT = 15;
    localparam int WAIT_W           = 4;

    // Opcodes carried in instr[15:12]; 4'h8..4'hE are illegal.
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h5;
    localparam logic [3:0] OP_ST   = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU selects; ALU_ADD doubles as the address add for LD/ST/JMP.
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    function automatic logic op_illegal(input logic [3:0] op);
        return (op >= 4'h8) && (op <= 4'hE);
    endfunction

    function automatic logic [2:0] alu_sel(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

    // Instructions that produce a register-file result in WB.
    function automatic logic op_writes_rf(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_LD);
    endfunction

    // Instructions that load the ALU result register in EXEC.
    function automatic logic op_uses_alu(input logic [3:0] op);
        return !((op == OP_NOP) || (op == OP_JMP) || (op == OP_HALT));
    endfunction

endpackage

// File: rtl/ssp_sequencer_if.sv
// ssp_sequencer_if: bundle between the sequencer and its environment.
// Inputs to the sequencer: start, instr, mem_ack.
// Outputs from the sequencer: datapath enables (pc/ir/a/b/alu/rf _we),
// mem_req/mem_we, rf_waddr, alu_op, busy/halted/error and the debug state.
// Handshake: mem_req is held high until a cycle with mem_ack=1 completes the
// access; mem_ack seen while mem_req=0 has no effect. start is a one-cycle
// pulse honoured only in IDLE.
interface ssp_sequencer_if;
    import ssp_pkg::*;

    logic        start;
    logic [15:0] instr;
    logic        mem_ack;

    logic        pc_we;
    logic        ir_we;
    logic        a_we;
    logic        b_we;
    logic        alu_we;
    logic        rf_we;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  rf_waddr;
    logic [2:0]  alu_op;
    logic        busy;
    logic        halted;
    logic        error;
    state_t      state;

    modport slave (
        input  start, instr, mem_ack,
        output pc_we, ir_we, a_we, b_we, alu_we, rf_we,
               mem_req, mem_we, rf_waddr, alu_op,
               busy, halted, error, state
    );

    modport master (
        output start, instr, mem_ack,
        input  pc_we, ir_we, a_we, b_we, alu_we, rf_we,
               mem_req, mem_we, rf_waddr, alu_op,
               busy, halted, error, state
    );

endinterface

// File: rtl/ssp_wait_timer.sv
// ssp_wait_timer: memory-wait counter with timeout compare.
// Ports: clk, rst (sync, active-high); clr restarts the count when the FSM
// enters a memory-wait state; stall marks a cycle with mem_req=1 and
// mem_ack=0; timeout is high on the stall cycle that brings the count to
// WAIT_MAX, so the FSM leaves for ERR after exactly WAIT_MAX stall cycles.
module ssp_wait_timer
    import ssp_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
)
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic stall,
    output logic timeout
);

    localparam logic [WAIT_W-1:0] LAST_BEFORE_MAX = WAIT_W'(WAIT_MAX - 1);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (stall) begin
            count <= count + 1'b1;
        end
    end

    // A cycle with mem_ack is never a stall, so an ack on the limit cycle wins.
    assign timeout = stall && (count == LAST_BEFORE_MAX);

endmodule

// File: rtl/ssp_sequencer.sv
// ssp_sequencer: multi-cycle instruction sequencer driving datapath enables.
// Ports: clk, rst (sync, active-high), bus (ssp_sequencer_if.slave) carrying
// start/instr/mem_ack in and enables, memory request, rf_waddr, alu_op,
// status flags and the debug state out.
// Flow: IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> WB -> FETCH, with HALT
// and ERR as terminal states left only through rst.
module ssp_sequencer
    import ssp_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
)
(
    input  logic              clk,
    input  logic              rst,
    ssp_sequencer_if.slave    bus
);

    state_t     state;
    state_t     state_next;
    logic [3:0] opcode;
    logic [3:0] dest;
    logic       unused_instr_bits;

    logic       pc_we, ir_we, a_we, b_we, alu_we, rf_we;
    logic       mem_req, mem_we;
    logic [3:0] rf_waddr;
    logic [2:0] alu_op;
    logic       busy, halted, error;

    logic       wait_enter;
    logic       stall;
    logic       timeout;

    assign opcode            = bus.instr[15:12];
    assign dest              = bus.instr[11:8];
    assign unused_instr_bits = ^bus.instr[7:0];

    // The counter restarts on every entry into a memory-wait state.
    assign wait_enter = (state_next != state) &&
                        ((state_next == ST_FETCH) || (state_next == ST_MEM));
    assign stall      = mem_req && !bus.mem_ack;

    ssp_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (wait_enter),
        .stall   (stall),
        .timeout (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bus.start) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.mem_ack)   state_next = ST_DECODE;
                else if (timeout)  state_next = ST_ERR;
            end
            ST_DECODE: begin
                state_next = op_illegal(opcode) ? ST_ERR : ST_EXEC;
            end
            ST_EXEC: begin
                if ((opcode == OP_LD) || (opcode == OP_ST)) state_next = ST_MEM;
                else if (opcode == OP_HALT)                 state_next = ST_HALT;
                else                                        state_next = ST_WB;
            end
            ST_MEM: begin
                if (bus.mem_ack)   state_next = ST_WB;
                else if (timeout)  state_next = ST_ERR;
            end
            ST_WB:   state_next = ST_FETCH;
            ST_HALT: state_next = ST_HALT;
            ST_ERR:  state_next = ST_ERR;
            default: state_next = ST_IDLE;
        endcase
    end

    // Each state owns at most one enable group, so the groups never overlap.
    always_comb begin
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        a_we     = 1'b0;
        b_we     = 1'b0;
        alu_we   = 1'b0;
        rf_we    = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        rf_waddr = 4'd0;
        busy     = 1'b0;
        halted   = 1'b0;
        error    = 1'b0;
        alu_op   = alu_sel(opcode);
        case (state)
            ST_FETCH: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                ir_we   = bus.mem_ack;
            end
            ST_DECODE: begin
                busy = 1'b1;
                a_we = !op_illegal(opcode);
                b_we = !op_illegal(opcode);
            end
            ST_EXEC: begin
                busy   = 1'b1;
                alu_we = op_uses_alu(opcode);
            end
            ST_MEM: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = (opcode == OP_ST);
            end
            ST_WB: begin
                busy     = 1'b1;
                pc_we    = 1'b1;
                rf_we    = op_writes_rf(opcode);
                rf_waddr = op_writes_rf(opcode) ? dest : 4'd0;
            end
            ST_HALT: halted = 1'b1;
            ST_ERR:  error  = 1'b1;
            default: ;
        endcase
    end

    assign bus.pc_we    = pc_we;
    assign bus.ir_we    = ir_we;
    assign bus.a_we     = a_we;
    assign bus.b_we     = b_we;
    assign bus.alu_we   = alu_we;
    assign bus.rf_we    = rf_we;
    assign bus.mem_req  = mem_req;
    assign bus.mem_we   = mem_we;
    assign bus.rf_waddr = rf_waddr;
    assign bus.alu_op   = alu_op;
    assign bus.busy     = busy;
    assign bus.halted   = halted;
    assign bus.error    = error;
    assign bus.state    = state;

endmodule

// File: tb/tb_ssp_sequencer.sv
// tb_ssp_sequencer: directed bench for ssp_sequencer.
// Each cycle the bench drives rst/start/mem_ack on the falling edge, waits
// 1 ns, and compares a packed snapshot {state, status, enables, rf_waddr,
// alu_op} against the next hand-written entry of the expected queue.
module tb_ssp_sequencer;
    import ssp_pkg::*;

    localparam int WM = 15;
    localparam int W  = 21;

    localparam logic [17:0] M_BUSY  = 18'h20000;
    localparam logic [17:0] M_HALT  = 18'h10000;
    localparam logic [17:0] M_ERR   = 18'h08000;
    localparam logic [17:0] M_MREQ  = 18'h04000;
    localparam logic [17:0] M_MWE   = 18'h02000;
    localparam logic [17:0] M_PCWE  = 18'h01000;
    localparam logic [17:0] M_IRWE  = 18'h00800;
    localparam logic [17:0] M_AWE   = 18'h00400;
    localparam logic [17:0] M_BWE   = 18'h00200;
    localparam logic [17:0] M_ALUWE = 18'h00100;
    localparam logic [17:0] M_RFWE  = 18'h00080;
    localparam logic [17:0] M_NONE  = 18'h00000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ssp_sequencer_if bus();

    ssp_sequencer #(.WAIT_MAX(WM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard ----------------
    int             checks = 0;
    int             errors = 0;
    logic [W-1:0]   exp_q[$];
    string          cur = "reset";
    int             cyc_n = 0;

    function automatic logic [W-1:0] ev(input state_t s, input logic [17:0] flags,
                                        input logic [3:0] wa, input logic [2:0] aop);
        return {s, flags | {11'd0, wa, aop}};
    endfunction

    function automatic logic [W-1:0] observe();
        return {bus.state, bus.busy, bus.halted, bus.error, bus.mem_req, bus.mem_we,
                bus.pc_we, bus.ir_we, bus.a_we, bus.b_we, bus.alu_we, bus.rf_we,
                bus.rf_waddr, bus.alu_op};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push(input state_t s, input logic [17:0] flags,
                        input logic [3:0] wa, input logic [2:0] aop);
        exp_q.push_back(ev(s, flags, wa, aop));
    endtask

    task automatic step(input logic r, input logic s, input logic a);
        logic [W-1:0] e;
        @(negedge clk);
        rst         = r;
        bus.start   = s;
        bus.mem_ack = a;
        #1;
        cyc_n++;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.c%0d no expected entry", cur, cyc_n);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("%s.c%0d", cur, cyc_n), observe(), e);
        end
    endtask

    // One reset cycle with the new instruction applied; the next step sees IDLE.
    task automatic start_test(input string nm, input logic [15:0] ins);
        @(negedge clk);
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.mem_ack = 1'b0;
        bus.instr   = ins;
        cur         = nm;
        cyc_n       = 0;
    endtask

    // Non-memory instruction with zero-wait fetch: 4 cycles start to FETCH.
    task automatic alu_seq(input string nm, input logic [15:0] ins, input logic [2:0] aop,
                           input logic [17:0] exec_f, input logic [17:0] wb_f,
                           input logic [3:0] wa);
        start_test(nm, ins);
        push(ST_IDLE,   M_NONE,                  4'd0, aop);
        push(ST_FETCH,  M_BUSY | M_MREQ | M_IRWE, 4'd0, aop);
        push(ST_DECODE, M_BUSY | M_AWE | M_BWE,   4'd0, aop);
        push(ST_EXEC,   M_BUSY | exec_f,          4'd0, aop);
        push(ST_WB,     M_BUSY | M_PCWE | wb_f,   wa,   aop);
        push(ST_FETCH,  M_BUSY | M_MREQ,          4'd0, aop);
        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
    endtask

    task automatic illegal_seq(input string nm, input logic [15:0] ins);
        start_test(nm, ins);
        push(ST_IDLE,   M_NONE,                  4'd0, ALU_ADD);
        push(ST_FETCH,  M_BUSY | M_MREQ | M_IRWE, 4'd0, ALU_ADD);
        push(ST_DECODE, M_BUSY,                  4'd0, ALU_ADD);
        push(ST_ERR,    M_ERR,                   4'd0, ALU_ADD);
        push(ST_ERR,    M_ERR,                   4'd0, ALU_ADD);
        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 1, 1);
        step(0, 0, 0);
    endtask

    // alu_op for opcodes 0..F, hand-derived.
    logic [2:0] aop_tab [16] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd0,
                                 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst         = 1'b1;
        bus.start   = 1'b1;
        bus.mem_ack = 1'b0;
        bus.instr   = 16'h0000;

        // rst held 3 cycles with start high, then released: stays IDLE.
        for (int i = 0; i < 4; i++) push(ST_IDLE, M_NONE, 4'd0, ALU_ADD);
        step(1, 1, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        step(0, 0, 0);

        // alu_op decode in IDLE for every opcode; mem_ack without mem_req ignored.
        cur = "aluop";
        cyc_n = 0;
        for (int op = 0; op < 16; op++) begin
            logic [3:0] op4;
            op4 = 4'(op);
            bus.instr = {op4, 12'h000};
            push(ST_IDLE, M_NONE, 4'd0, aop_tab[op]);
            step(0, 0, 1);
        end

        alu_seq("add", 16'h1300, 3'd0, M_ALUWE, M_RFWE, 4'd3);
        alu_seq("sub", 16'h2A00, 3'd1, M_ALUWE, M_RFWE, 4'hA);
        alu_seq("and", 16'h3400, 3'd2, M_ALUWE, M_RFWE, 4'd4);
        alu_seq("or",  16'h4F00, 3'd3, M_ALUWE, M_RFWE, 4'hF);
        alu_seq("nop", 16'h0000, 3'd0, M_NONE,  M_NONE, 4'd0);
        alu_seq("jmp", 16'h7500, 3'd0, M_NONE,  M_NONE, 4'd0);

        // LD with ack delayed 3 cycles in MEM.
        start_test("ld", 16'h5200);
        push(ST_IDLE,   M_NONE,                   4'd0, 3'd0);
        push(ST_FETCH,  M_BUSY | M_MREQ | M_IRWE,  4'd0, 3'd0);
        push(ST_DECODE, M_BUSY | M_AWE | M_BWE,    4'd0, 3'd0);
        push(ST_EXEC,   M_BUSY | M_ALUWE,          4'd0, 3'd0);
        for (int i = 0; i < 4; i++) push(ST_MEM, M_BUSY | M_MREQ, 4'd0, 3'd0);
        push(ST_WB,     M_BUSY | M_PCWE | M_RFWE,  4'd2, 3'd0);
        push(ST_FETCH,  M_BUSY | M_MREQ,           4'd0, 3'd0);
        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);

        // ST: mem_we in MEM, no rf_we in WB.
        start_test("st", 16'h6000);
        push(ST_IDLE,   M_NONE,                    4'd0, 3'd0);
        push(ST_FETCH,  M_BUSY | M_MREQ | M_IRWE,   4'd0, 3'd0);
        push(ST_DECODE, M_BUSY | M_AWE | M_BWE,     4'd0, 3'd0);
        push(ST_EXEC,   M_BUSY | M_ALUWE,           4'd0, 3'd0);
        push(ST_MEM,    M_BUSY | M_MREQ | M_MWE,    4'd0, 3'd0);
        push(ST_WB,     M_BUSY | M_PCWE,            4'd0, 3'd0);
        push(ST_FETCH,  M_BUSY | M_MREQ,            4'd0, 3'd0);
        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);

        illegal_seq("ill9", 16'h9000);
        illegal_seq("ill8", 16'h8000);
        illegal_seq("illE", 16'hE000);

        // HALT is terminal; start and mem_ack are ignored there.
        start_test("halt", 16'hF000);
        push(ST_IDLE,   M_NONE,                   4'd0, 3'd0);
        push(ST_FETCH,  M_BUSY | M_MREQ | M_IRWE,  4'd0, 3'd0);
        push(ST_DECODE, M_BUSY | M_AWE | M_BWE,    4'd0, 3'd0);
        push(ST_EXEC,   M_BUSY,                    4'd0, 3'd0);
        push(ST_HALT,   M_HALT,                    4'd0, 3'd0);
        push(ST_HALT,   M_HALT,                    4'd0, 3'd0);
        push(ST_HALT,   M_HALT,                    4'd0, 3'd0);
        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 1);
        step(0, 0, 0);
        step(0, 0, 0);

        // Fetch timeout: WM stall cycles, then ERR; start afterwards ignored.
        start_test("fetch_to", 16'h1000);
        push(ST_IDLE, M_NONE, 4'd0, 3'd0);
        for (int i = 0; i < WM; i++) push(ST_FETCH, M_BUSY | M_MREQ, 4'd0, 3'd0);
        push(ST_ERR, M_ERR, 4'd0, 3'd0);
        push(ST_ERR, M_ERR, 4'd0, 3'd0);
        push(ST_ERR, M_ERR, 4'd0, 3'd0);
        step(0, 1, 0);
        for (int i = 0; i < WM; i++) step(0, 0, 0);
        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 0, 0);

        // Ack on the last allowed FETCH cycle wins over the timeout.
        start_test("ack_edge", 16'h1000);
        push(ST_IDLE, M_NONE, 4'd0, 3'd0);
        for (int i = 0; i < WM - 1; i++) push(ST_FETCH, M_BUSY | M_MREQ, 4'd0, 3'd0);
        push(ST_FETCH,  M_BUSY | M_MREQ | M_IRWE, 4'd0, 3'd0);
        push(ST_DECODE, M_BUSY | M_AWE | M_BWE,   4'd0, 3'd0);
        step(0, 1, 0);
        for (int i = 0; i < WM - 1; i++) step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);

        // Counter restarts on MEM entry: 10 fetch stalls, then a full WM in MEM.
        start_test("mem_to", 16'h5000);
        push(ST_IDLE, M_NONE, 4'd0, 3'd0);
        for (int i = 0; i < 10; i++) push(ST_FETCH, M_BUSY | M_MREQ, 4'd0, 3'd0);
        push(ST_FETCH,  M_BUSY | M_MREQ | M_IRWE, 4'd0, 3'd0);
        push(ST_DECODE, M_BUSY | M_AWE | M_BWE,   4'd0, 3'd0);
        push(ST_EXEC,   M_BUSY | M_ALUWE,         4'd0, 3'd0);
        for (int i = 0; i < WM; i++) push(ST_MEM, M_BUSY | M_MREQ, 4'd0, 3'd0);
        push(ST_ERR, M_ERR, 4'd0, 3'd0);
        step(0, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < WM; i++) step(0, 0, 0);
        step(0, 0, 0);

        // rst during MEM: IDLE on the next cycle, mem_req dropped.
        start_test("rst_mem", 16'h5000);
        push(ST_IDLE,   M_NONE,                   4'd0, 3'd0);
        push(ST_FETCH,  M_BUSY | M_MREQ | M_IRWE,  4'd0, 3'd0);
        push(ST_DECODE, M_BUSY | M_AWE | M_BWE,    4'd0, 3'd0);
        push(ST_EXEC,   M_BUSY | M_ALUWE,          4'd0, 3'd0);
        push(ST_MEM,    M_BUSY | M_MREQ,           4'd0, 3'd0);
        push(ST_MEM,    M_BUSY | M_MREQ,           4'd0, 3'd0);
        push(ST_IDLE,   M_NONE,                    4'd0, 3'd0);
        push(ST_IDLE,   M_NONE,                    4'd0, 3'd0);
        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 1, 1);
        step(0, 0, 1);
        step(0, 0, 0);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover expected entries=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssp_sequencer.md
SSP_SEQUENCER -- requirements
Module: ssp_sequencer

Interface
REQ-001 Parameter: WAIT_MAX, default 15, maximum memory-wait cycles before the block declares a timeout.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  one-cycle pulse; begins instruction execution from IDLE.
REQ-005 instr  input  16  instruction register contents; opcode is instr[15:12], destination is instr[11:8].
REQ-006 mem_ack  input  1  memory completes the current access this cycle.
REQ-007 Enables, each output 1 bit: pc_we, ir_we, a_we, b_we, alu_we, rf_we; these are the write enables of the datapath enable-registers.
REQ-008 mem_req, mem_we  output  1  memory access request; mem_we=1 for a store.
REQ-009 rf_waddr  output  4  register-file write address.
REQ-010 alu_op  output  3  ALU operation select.
REQ-011 busy, halted, error  output  1  status flags.

Function
REQ-012 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR. The state is held in a registered state variable.
REQ-013 IDLE: all enables are 0 and busy=0; start=1 moves the block to FETCH on the next edge. start is ignored in every other state.
REQ-014 FETCH: mem_req=1 and mem_we=0 until mem_ack is seen.
  - On the cycle mem_ack=1: ir_we=1, and the block moves to DECODE.
REQ-015 DECODE: a_we=1 and b_we=1 for exactly one cycle, then the block moves to EXEC.
  - An illegal opcode moves the block to ERR instead, with a_we=b_we=0.
REQ-016 Opcodes:
  - 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 LD, 6 ST, 7 JMP, F HALT.
  - 8 to E are illegal.
REQ-017 alu_op is driven as a combinational function of the opcode in every state:
  - ADD=0, SUB=1, AND=2, OR=3.
  - All other opcodes give 0 (address add).
REQ-018 EXEC: alu_we=1 for one cycle, except for NOP, JMP and HALT. Next state:
  - LD or ST: MEM.
  - HALT: HALT.
  - All others: WB.
REQ-019 MEM: mem_req=1, and mem_we=1 for ST only, held until mem_ack. On the ack cycle the block moves to WB.
REQ-020 WB: pc_we=1 for one cycle.
  - rf_we=1 for ADD, SUB, AND, OR and LD, with rf_waddr=instr[11:8].
  - rf_we=0 for NOP, ST and JMP.
  - Next state is FETCH.
REQ-021 rf_waddr is 0 whenever rf_we=0.
REQ-022 Wait counter, 4 bits wide:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle in which mem_req=1 and mem_ack=0.
  - When it reaches WAIT_MAX with mem_ack=0, the block moves to ERR on the next edge.
  - mem_ack takes priority on the cycle the count reaches WAIT_MAX.
REQ-023 HALT: halted=1 and all enables 0; the block stays there until rst.
REQ-024 ERR: error=1 and all enables 0; the block stays there until rst.
REQ-025 busy=1 in FETCH, DECODE, EXEC, MEM and WB.
REQ-026 mem_ack arriving while mem_req=0 is ignored.
REQ-027 At most one of the following is asserted in any cycle: ir_we, {a_we,b_we}, alu_we, {pc_we,rf_we}.
REQ-028 Latency with zero-wait memory:
  - ALU instruction: 4 cycles, start to next FETCH.
  - LD/ST: 5 cycles.

Reset
REQ-029 When rst=1 at a rising edge, the state becomes IDLE and the wait counter becomes 0, regardless of current state, including mid-access.
REQ-030 After reset, all outputs are 0: enables, mem_req, mem_we, rf_waddr, alu_op (for opcode 0), busy, halted and error.
REQ-031 rst takes priority over start, mem_ack and the timeout.

Structure
REQ-032 A shared package ssp_pkg holds:
  - opcode constants;
  - alu_op encodings;
  - state encoding constants;
  - the WAIT_MAX default.
REQ-033 One sub-module, ssp_wait_timer, holds the wait counter and the timeout compare. All other logic is a single FSM with a combinational output decode.

Verification
REQ-034 rst, then start; instr=0x1300 (ADD r3); mem_ack on the first FETCH cycle. Required cycle sequence:
  - ir_we
  - a_we/b_we
  - alu_we (alu_op=0)
  - pc_we with rf_we and rf_waddr=3
  - then FETCH.
REQ-035 LD, instr=0x5200, with mem_ack delayed 3 cycles in MEM:
  - mem_req held 4 cycles with mem_we=0;
  - then rf_we with rf_waddr=2.
REQ-036 ST, instr=0x6000: mem_we=1 in MEM, and rf_we stays 0 in WB.
REQ-037 mem_ack withheld in FETCH:
  - ERR is entered after WAIT_MAX stall cycles, with error=1 and busy=0;
  - a subsequent start is ignored.
REQ-038 instr=0x9000: ERR is entered from DECODE, with no a_we/b_we pulse.
REQ-039 Further directed cases:
  - instr=0xF000: halted=1, and the block stays in HALT.
  - rst asserted during MEM: the block returns to IDLE next cycle with mem_req=0.
  - rst held for 3 cycles while start=1: the block remains in IDLE.
